// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first,
// and holds the difference with borrow, overflow and zero flags until acknowledged.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    input  logic             Bin,
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic [0:WIDTH-1] D,
    output logic             Bout,
    output logic             V,
    output logic             Z,
    output logic             valid
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [0:WIDTH-1] a_q;
    logic [0:WIDTH-1] b_q;
    logic             br_q;
    logic [CNT_W-1:0] cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [0:WIDTH-1] d_next;

    // One full-subtractor cell; the difference vector is updated in place so
    // the zero flag can be taken from the value that is about to be stored.
    always_comb begin
        a_bit   = a_q[cnt];
        b_bit   = b_q[cnt];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        d_next      = D;
        d_next[cnt] = d_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            valid <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            br_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        br_q  <= Bin;
                        cnt   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    D    <= d_next;
                    br_q <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Bout  <= br_next;
                        V     <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
                        Z     <= ~|d_next;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, even alongside ack
                    if (ack) begin
                        valid <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8,
// compared against an arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ack = 1'b0;
    logic bin = 1'b0;
    logic start4 = 1'b0;
    logic start8 = 1'b0;

    logic [0:3] a4 = '0, b4 = '0, d4;
    logic [0:7] a8 = '0, b8 = '0, d8;
    logic ready4, busy4, bout4, v4, z4, valid4;
    logic ready8, busy8, bout8, v8, z8, valid8;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Bin(bin), .ack(ack),
        .ready(ready4), .busy(busy4), .D(d4), .Bout(bout4), .V(v4), .Z(z4), .valid(valid4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin), .ack(ack),
        .ready(ready8), .busy(busy8), .D(d8), .Bout(bout8), .V(v8), .Z(z8), .valid(valid8)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Ports use index 0 = LSB, so numeric values are mapped bit by bit.
    function automatic logic [0:3] pk4(input int v);
        logic [0:3] r;
        for (int i = 0; i < 4; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [0:7] pk8(input int v);
        logic [0:7] r;
        for (int i = 0; i < 8; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic int unpk4(input logic [0:3] x);
        int r = 0;
        for (int i = 0; i < 4; i++) r[i] = x[i];
        return r;
    endfunction

    function automatic int unpk8(input logic [0:7] x);
        int r = 0;
        for (int i = 0; i < 8; i++) r[i] = x[i];
        return r;
    endfunction

    task automatic model(input int w, input int a, input int b, input int bi,
                         output int d, output int bo, output int v, output int z);
        int mask;
        mask = (1 << w) - 1;
        d  = (a - b - bi) & mask;
        bo = (a < b + bi) ? 1 : 0;
        v  = ((((a >> (w-1)) & 1) != ((b >> (w-1)) & 1)) &&
              (((d >> (w-1)) & 1) != ((a >> (w-1)) & 1))) ? 1 : 0;
        z  = (d == 0) ? 1 : 0;
    endtask

    task automatic sample(input int w, output int d, output int bo, output int v, output int z,
                          output int rdy, output int bsy, output int vld);
        if (w == 4) begin
            d = unpk4(d4); bo = bout4; v = v4; z = z4; rdy = ready4; bsy = busy4; vld = valid4;
        end else begin
            d = unpk8(d8); bo = bout8; v = v8; z = z8; rdy = ready8; bsy = busy8; vld = valid8;
        end
    endtask

    task automatic scramble(input int w);
        if (w == 4) begin a4 = pk4($urandom); b4 = pk4($urandom); end
        else begin a8 = pk8($urandom); b8 = pk8($urandom); end
        bin = 1'($urandom);
    endtask

    task automatic launch(input string tag, input int w, input int a, input int b, input int bi);
        int d, bo, v, z, rdy, bsy, vld;
        @(negedge clk);
        if (w == 4) begin a4 = pk4(a); b4 = pk4(b); start4 = 1'b1; end
        else begin a8 = pk8(a); b8 = pk8(b); start8 = 1'b1; end
        bin = 1'(bi);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        sample(w, d, bo, v, z, rdy, bsy, vld);
        chk({tag, ".busy_run"}, bsy, 1);
        chk({tag, ".ready_run"}, rdy, 0);
    endtask

    // Operands are scrambled every cycle of the run; the latched ones must win.
    task automatic wait_done(input string tag, input int w);
        int d, bo, v, z, rdy, bsy, vld;
        for (int k = 0; k < w - 1; k++) begin
            scramble(w);
            @(negedge clk);
        end
        sample(w, d, bo, v, z, rdy, bsy, vld);
        chk({tag, ".valid_early"}, vld, 0);
        @(negedge clk);
        sample(w, d, bo, v, z, rdy, bsy, vld);
        chk({tag, ".valid"}, vld, 1);
        chk({tag, ".busy_done"}, bsy, 0);
    endtask

    task automatic check_res(input string tag, input int w, input int a, input int b, input int bi);
        int ed, ebo, ev, ez, d, bo, v, z, rdy, bsy, vld;
        model(w, a, b, bi, ed, ebo, ev, ez);
        sample(w, d, bo, v, z, rdy, bsy, vld);
        chk({tag, ".D"}, d, ed);
        chk({tag, ".Bout"}, bo, ebo);
        chk({tag, ".V"}, v, ev);
        chk({tag, ".Z"}, z, ez);
    endtask

    task automatic do_ack(input string tag, input int w);
        int d, bo, v, z, rdy, bsy, vld;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        sample(w, d, bo, v, z, rdy, bsy, vld);
        chk({tag, ".ready_ack"}, rdy, 1);
        chk({tag, ".valid_ack"}, vld, 0);
    endtask

    task automatic full(input string tag, input int w, input int a, input int b, input int bi);
        launch(tag, w, a, b, bi);
        wait_done(tag, w);
        check_res(tag, w, a, b, bi);
        do_ack(tag, w);
    endtask

    initial begin
        int d, bo, v, z, rdy, bsy, vld;
        int busy_seen, valid_seen;

        #2 rst_n = 1'b0;
        #1;
        sample(4, d, bo, v, z, rdy, bsy, vld);
        chk("rst.ready", rdy, 1);
        chk("rst.busy", bsy, 0);
        chk("rst.valid", vld, 0);
        chk("rst.D", d, 0);
        chk("rst.flags", bo + v + z, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle with start low: nothing happens.
        repeat (3) begin
            scramble(4);
            @(negedge clk);
        end
        sample(4, d, bo, v, z, rdy, bsy, vld);
        chk("idle.ready", rdy, 1);
        chk("idle.busy", bsy, 0);

        full("d9m3", 4, 9, 3, 0);
        full("d3m9", 4, 3, 9, 0);
        full("d7m8", 4, 7, 8, 0);
        full("d0m0b", 4, 0, 0, 1);
        full("d5m5", 4, 5, 5, 0);
        full("d8m0b", 4, 8, 0, 1);

        // Hold in DONE without ack while inputs toggle and start pulses.
        launch("hold", 4, 9, 3, 0);
        wait_done("hold", 4);
        busy_seen = 0;
        for (int k = 0; k < 20; k++) begin
            a4 = pk4($urandom);
            b4 = pk4($urandom);
            start4 = 1'(k % 2);
            @(negedge clk);
            sample(4, d, bo, v, z, rdy, bsy, vld);
            if (bsy != 0 || rdy != 0 || vld != 1) busy_seen = 1;
        end
        start4 = 1'b0;
        chk("hold.state", busy_seen, 0);
        check_res("hold", 4, 9, 3, 0);
        ack = 1'b1;
        start4 = 1'b1;
        a4 = pk4(1);
        b4 = pk4(1);
        @(negedge clk);
        ack = 1'b0;
        start4 = 1'b0;
        sample(4, d, bo, v, z, rdy, bsy, vld);
        chk("ackstart.ready", rdy, 1);
        chk("ackstart.valid", vld, 0);
        @(negedge clk);
        sample(4, d, bo, v, z, rdy, bsy, vld);
        chk("ackstart.not_started", bsy, 0);
        check_res("idle_keep", 4, 9, 3, 0);

        // Reset in the middle of a run.
        launch("abort", 4, 9, 3, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sample(4, d, bo, v, z, rdy, bsy, vld);
        chk("abort.ready", rdy, 1);
        chk("abort.busy", bsy, 0);
        chk("abort.valid", vld, 0);
        chk("abort.D", d, 0);
        chk("abort.flags", bo + v + z, 0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_seen = 0;
        repeat (6) begin
            @(negedge clk);
            sample(4, d, bo, v, z, rdy, bsy, vld);
            valid_seen |= vld;
        end
        chk("abort.no_valid", valid_seen, 0);
        full("after_rst", 4, 12, 4, 0);

        // Every operand combination at WIDTH=4.
        for (int i = 0; i < 512; i++)
            full("exh4", 4, i & 15, (i >> 4) & 15, (i >> 8) & 1);

        // Random sweep at WIDTH=8.
        for (int i = 0; i < 200; i++)
            full("rnd8", 8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
